// File: rtl/data_sram_like_bridge_pkg.sv
// Shared types for the data-port to sram-like bridge: FSM states, transfer size codes
// and the write-strobe to transfer-size decode.
package data_sram_like_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_RDATA = 2'd2
    } bridge_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Single-byte and aligned half-word strobes get a narrow size; anything else is a word.
    function automatic logic [1:0] strb_to_size(input logic [3:0] strb);
        case (strb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return SZ_BYTE;
            4'b0011, 4'b1100:                   return SZ_HALF;
            default:                            return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/data_sram_like_bridge.sv
// Turns the core's fixed-latency data-memory accesses into sram-like req/addr_ok/data_ok
// transactions, posting writes up to MAX_WR_OUTSTANDING and stalling the core otherwise.
module data_sram_like_bridge
    import data_sram_like_bridge_pkg::*;
#(
    parameter int MAX_WR_OUTSTANDING = 2,
    parameter int ADDR_W             = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        dbg_state,
    output logic [2:0]        dbg_wr_cnt
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_WR_OUTSTANDING);

    // Core handshake: the core holds cpu_en and its fields while cpu_stall=1; an access
    // is taken on a rising edge where cpu_en=1 and cpu_stall=0. Memory handshake: the
    // request fields stay stable while mem_req=1 until a cycle with mem_addr_ok=1; each
    // accepted request later gets exactly one mem_data_ok, in order.
    bridge_state_e state;
    logic [2:0]    wr_cnt;
    logic          is_write;
    logic          accept;
    logic          wr_inc;
    logic          wr_dec;

    assign is_write = |cpu_we;

    // Reads must wait for every posted write to be acknowledged.
    always_comb begin
        accept = 1'b0;
        if (state == ST_IDLE && cpu_en)
            accept = is_write ? (wr_cnt < MAX_CNT) : (wr_cnt == 3'd0);
    end

    assign cpu_stall = cpu_en & ~accept;

    assign wr_inc = (state == ST_ADDR) && mem_addr_ok && mem_wr;
    // A data_ok with nothing posted is a protocol error and is dropped.
    assign wr_dec = (state != ST_RDATA) && mem_data_ok && (wr_cnt != 3'd0);

    assign dbg_state  = state;
    assign dbg_wr_cnt = wr_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            wr_cnt     <= 3'd0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= 32'd0;
            mem_req    <= 1'b0;
            mem_wr     <= 1'b0;
            mem_size   <= 2'd0;
            mem_wstrb  <= 4'd0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
        end else begin
            cpu_rvalid <= 1'b0;

            case ({wr_inc, wr_dec})
                2'b10:   wr_cnt <= wr_cnt + 3'd1;
                2'b01:   wr_cnt <= wr_cnt - 3'd1;
                default: wr_cnt <= wr_cnt;
            endcase

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mem_req   <= 1'b1;
                        mem_wr    <= is_write;
                        mem_size  <= is_write ? strb_to_size(cpu_we) : SZ_WORD;
                        mem_wstrb <= cpu_we;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (mem_addr_ok) begin
                        mem_req <= 1'b0;
                        state   <= mem_wr ? ST_IDLE : ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (mem_data_ok) begin
                        cpu_rdata  <= mem_rdata;
                        cpu_rvalid <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Self-checking bench for data_sram_like_bridge: transaction-level model of the core port
// and a randomised in-order sram-like responder, compared every cycle.
module tb_data_sram_like_bridge;
    import data_sram_like_bridge_pkg::*;

    localparam int MAX = 2;
    localparam int AW  = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cpu_en;
    logic [3:0]    cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_stall;
    logic          cpu_rvalid;
    logic [31:0]   cpu_rdata;
    logic          mem_req;
    logic          mem_wr;
    logic [1:0]    mem_size;
    logic [3:0]    mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_addr_ok;
    logic          mem_data_ok;
    logic [31:0]   mem_rdata;
    logic [1:0]    dbg_state;
    logic [2:0]    dbg_wr_cnt;

    always #5 clk = ~clk;

    data_sram_like_bridge #(.MAX_WR_OUTSTANDING(MAX), .ADDR_W(AW)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state), .dbg_wr_cnt(dbg_wr_cnt)
    );

    typedef struct { logic [3:0] we; logic [31:0] addr; logic [31:0] wdata; } op_t;
    typedef struct { logic is_read; logic [31:0] data; int due; } resp_t;
    typedef struct { int cyc; logic wr; logic [1:0] size; logic [3:0] strb; int req_cycles; } hs_t;

    op_t         op_q[$];
    resp_t       resp_q[$];
    hs_t         hs_log[$];
    int          acc_log[$];
    int          wack_log[$];
    int          rv_log[$];
    logic [31:0] exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state: busy 0 = free, 1 = request waiting for addr_ok, 2 = read waiting for data
    int          busy = 0;
    op_t         cur;
    int          wcnt = 0;
    logic        rv_exp = 1'b0;
    logic [31:0] last_rdata = 32'd0;
    logic        took = 1'b0;
    int          req_cnt = 0;

    // responder knobs
    int          aok_pct = 100;
    int          aok_hold = 0;
    int          dly_fixed = 0;
    int          dly_max = 6;
    bit          spurious_en = 1'b0;
    bit          rd_fixed_en = 1'b0;
    logic [31:0] rd_fixed = 32'd0;
    int          rand_left = 0;

    logic        exp_stall;
    resp_t       r;
    int          d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_size(input logic [3:0] s);
        if (s == 4'b0000) return 2'd2;
        if ($countones(s) == 1) return 2'd0;
        if (s == 4'b0011 || s == 4'b1100) return 2'd1;
        return 2'd2;
    endfunction

    task automatic clear_model();
        resp_q.delete();
        exp_q.delete();
        busy = 0; wcnt = 0; rv_exp = 1'b0; last_rdata = 32'd0; took = 1'b0; req_cnt = 0;
    endtask

    task automatic clear_logs();
        hs_log.delete(); acc_log.delete(); wack_log.delete(); rv_log.delete();
    endtask

    task automatic push_op(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
        op_t o;
        o.we = we; o.addr = addr; o.wdata = wdata;
        op_q.push_back(o);
    endtask

    task automatic wait_quiet(input string tag, input int limit);
        int n = 0;
        while ((op_q.size() != 0 || rand_left != 0 || busy != 0 || resp_q.size() != 0 || cpu_en)
               && n < limit) begin
            @(posedge clk); #2;
            n++;
        end
        total++;
        if (n >= limit) begin
            bad++;
            $display("FAIL timeout_%s: got busy after %0d cycles want quiet", tag, n);
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    // Drive core and memory inputs just after each rising edge.
    initial forever begin
        @(posedge clk); #1;
        cyc++;
        if (!resetn) begin
            cpu_en = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        end else begin
            if (!cpu_en || took) begin
                if (op_q.size() > 0) begin
                    op_t o;
                    o = op_q.pop_front();
                    cpu_en = 1'b1; cpu_we = o.we; cpu_addr = o.addr; cpu_wdata = o.wdata;
                end else if (rand_left > 0 && $urandom_range(0, 3) != 0) begin
                    int k;
                    k = $urandom_range(0, 2);
                    cpu_en = 1'b1;
                    cpu_we = (k == 0) ? 4'h0 : ((k == 1) ? 4'hf : 4'($urandom_range(1, 15)));
                    cpu_addr = $urandom; cpu_wdata = $urandom;
                    rand_left--;
                end else begin
                    cpu_en = 1'b0;
                    cpu_we = 4'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
                end
            end
            if (mem_req && aok_hold > 0) begin
                mem_addr_ok = 1'b0;
                aok_hold--;
            end else begin
                mem_addr_ok = ($urandom_range(1, 100) <= aok_pct);
            end
            if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
                mem_data_ok = 1'b1; mem_rdata = resp_q[0].data;
            end else if (resp_q.size() == 0 && spurious_en && $urandom_range(0, 19) == 0) begin
                mem_data_ok = 1'b1; mem_rdata = $urandom;
            end else begin
                mem_data_ok = 1'b0; mem_rdata = $urandom;
            end
        end
    end

    // Compare on the falling edge, then advance the model by what the coming edge will see.
    initial forever begin
        @(negedge clk);
        if (!resetn) begin
            clear_model();
        end else begin
            exp_stall = cpu_en && (busy != 0 || (cpu_we != 4'h0 ? wcnt >= MAX : wcnt != 0));
            chk("cpu_stall", cpu_stall, exp_stall);
            chk("mem_req", mem_req, busy == 1);
            if (busy == 1) begin
                req_cnt++;
                chk("mem_wr", mem_wr, cur.we != 4'h0);
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_wstrb", mem_wstrb, cur.we);
                chk("mem_size", mem_size, ref_size(cur.we));
                if (cur.we != 4'h0) chk("mem_wdata", mem_wdata, cur.wdata);
            end
            chk("cpu_rvalid", cpu_rvalid, rv_exp);
            chk("cpu_rdata_hold", cpu_rdata, last_rdata);
            chk("wr_cnt", dbg_wr_cnt, wcnt);
            if (cpu_rvalid) begin
                rv_log.push_back(cyc);
                if (exp_q.size() == 0) chk("rvalid_unexpected", 32'd1, 32'd0);
                else chk("rdata_scoreboard", cpu_rdata, exp_q.pop_front());
            end

            rv_exp = 1'b0;
            if (mem_data_ok && resp_q.size() > 0) begin
                r = resp_q.pop_front();
                if (r.is_read) begin
                    last_rdata = r.data; rv_exp = 1'b1; busy = 0;
                    exp_q.push_back(r.data);
                end else begin
                    wcnt--;
                    wack_log.push_back(cyc);
                end
            end
            if (busy == 1 && mem_addr_ok) begin
                hs_t h;
                h.cyc = cyc; h.wr = (cur.we != 4'h0); h.size = mem_size; h.strb = mem_wstrb;
                h.req_cycles = req_cnt;
                hs_log.push_back(h);
                req_cnt = 0;
                d = (dly_fixed >= 0) ? dly_fixed : $urandom_range(0, dly_max);
                r.due = cyc + 1 + d;
                if (cur.we != 4'h0) begin
                    wcnt++; busy = 0;
                    r.is_read = 1'b0; r.data = 32'd0;
                end else begin
                    busy = 2;
                    r.is_read = 1'b1; r.data = rd_fixed_en ? rd_fixed : $urandom;
                end
                resp_q.push_back(r);
            end
            took = 1'b0;
            if (cpu_en && !exp_stall) begin
                took = 1'b1; busy = 1;
                cur.we = cpu_we; cur.addr = cpu_addr; cur.wdata = cpu_wdata;
                acc_log.push_back(cyc);
            end
        end
    end

    initial begin
        resetn = 1'b0; cpu_en = 1'b0; cpu_we = 4'h0; cpu_addr = '0; cpu_wdata = 32'd0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
        #12;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_cpu_stall", cpu_stall, 1'b0);
        chk("rst_wr_cnt", dbg_wr_cnt, 3'd0);
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_mem_addr", mem_addr, 32'd0);
        @(posedge clk); #3;
        resetn = 1'b1;

        // zero-wait read
        clear_logs();
        aok_pct = 100; dly_fixed = 0; rd_fixed_en = 1'b1; rd_fixed = 32'hDEAD_BEEF;
        push_op(4'h0, 32'h1C00_0100, 32'd0);
        wait_quiet("zero_wait_read", 200);
        rd_fixed_en = 1'b0;
        chk("zw_rvalid_count", rv_log.size(), 1);
        chk("zw_latency", rv_log[0] - acc_log[0], 3);
        chk("zw_rdata", cpu_rdata, 32'hDEAD_BEEF);

        // posted writes, data_ok 5 cycles late
        clear_logs();
        dly_fixed = 5;
        for (int i = 0; i < 3; i++) push_op(4'hf, 32'h1000_0000 + 32'(i * 4), $urandom);
        wait_quiet("posted_writes", 200);
        chk("pw_accepts", acc_log.size(), 3);
        chk("pw_second_gap", acc_log[1] - acc_log[0], 2);
        chk("pw_third_gap", acc_log[2] - acc_log[0], 8);
        chk("pw_third_after_ack", acc_log[2] > wack_log[0], 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("pw_size", hs_log[i].size, 2'd2);
            chk("pw_strb", hs_log[i].strb, 4'hf);
        end

        // read right after a write
        clear_logs();
        dly_fixed = 4;
        push_op(4'hf, 32'h2000_0000, 32'h1234_5678);
        push_op(4'h0, 32'h2000_0000, 32'd0);
        wait_quiet("read_after_write", 200);
        chk("raw_read_gap", acc_log[1] - acc_log[0], 7);
        chk("raw_read_after_ack", hs_log[1].cyc > wack_log[0], 1'b1);
        chk("raw_read_kind", hs_log[1].wr, 1'b0);

        // size decode
        clear_logs();
        dly_fixed = 0;
        push_op(4'b0100, 32'h3000_0002, $urandom);
        push_op(4'b1100, 32'h3000_0002, $urandom);
        push_op(4'b0110, 32'h3000_0000, $urandom);
        wait_quiet("size_decode", 200);
        chk("sz_byte", hs_log[0].size, 2'd0);
        chk("sz_half", hs_log[1].size, 2'd1);
        chk("sz_word", hs_log[2].size, 2'd2);
        chk("sz_strb0", hs_log[0].strb, 4'b0100);
        chk("sz_strb1", hs_log[1].strb, 4'b1100);
        chk("sz_strb2", hs_log[2].strb, 4'b0110);

        // addr_ok held low for 6 request cycles, with a read queued behind
        clear_logs();
        dly_fixed = 2; aok_hold = 6;
        push_op(4'hf, 32'h4000_0010, 32'hCAFE_F00D);
        push_op(4'h0, 32'h4000_0010, 32'd0);
        wait_quiet("backpressure", 200);
        chk("bp_req_cycles", hs_log[0].req_cycles, 7);
        chk("bp_read_done", rv_log.size(), 1);

        // asynchronous reset while a read waits for data
        clear_logs();
        dly_fixed = 10;
        push_op(4'h0, 32'h5000_0000, 32'd0);
        begin
            int n = 0;
            while (busy != 2 && n < 100) begin @(posedge clk); #2; n++; end
            chk("rdata_state_reached", busy, 2);
        end
        @(posedge clk); #3;
        resetn = 1'b0;
        clear_model();
        #1;
        chk("ar_mem_req", mem_req, 1'b0);
        chk("ar_cpu_rvalid", cpu_rvalid, 1'b0);
        chk("ar_wr_cnt", dbg_wr_cnt, 3'd0);
        chk("ar_state", dbg_state, ST_IDLE);
        chk("ar_cpu_rdata", cpu_rdata, 32'd0);
        @(posedge clk); @(posedge clk); #3;
        resetn = 1'b1;
        clear_logs();
        dly_fixed = 0;
        push_op(4'h0, 32'h5000_0004, 32'd0);
        wait_quiet("read_after_reset", 200);
        chk("ar_next_read", rv_log.size(), 1);
        chk("ar_next_latency", rv_log[0] - acc_log[0], 3);

        // randomised traffic
        aok_pct = 60; dly_fixed = -1; dly_max = 6; spurious_en = 1'b1;
        rand_left = 300;
        wait_quiet("random", 20000);
        spurious_en = 1'b0;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
